cnn_window_scan_ctrl: RTL

Sliding-window scan controller for the CNN feature-map input path. It sits directly downstream of the pixel counter (`counter_cnn`). It drives the counter's `clear`/`keep` controls so that `count` tracks the pixels accepted from the input stream. It watches `count` to decide when each KxK convolution window has all its pixels buffered. Each complete window's position and base address is issued to the PE array over a valid/ready handshake.

---
 rtl/cnn_window_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cnn_window_scan_ctrl.sv
// Sliding-window scan controller: steers the pixel counter and issues one
// descriptor per complete KxK window (stride 1) over a valid/ready handshake.
//
//   state  | meaning
//   S_IDLE | counter held cleared, waiting for i_start
//   S_RUN  | accepting pixels and issuing window descriptors
//   S_DONE | one-cycle done pulse, counter cleared, back to idle
module cnn_window_scan_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic [15:0] i_pix_count,
    output logic        o_cnt_clear,
    output logic        o_cnt_keep,
    output logic        o_win_valid,
    input  logic        i_win_ready,
    output logic [7:0]  o_win_row,
    output logic [7:0]  o_win_col,
    output logic [15:0] o_win_base,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TOTAL    = 16'(IMG_W * IMG_H);
    localparam logic [15:0] W16      = 16'(IMG_W);
    localparam logic [15:0] KM1      = 16'(K - 1);
    localparam logic [15:0] K16      = 16'(K);
    localparam logic [7:0]  LAST_ROW = 8'(IMG_H - K);
    localparam logic [7:0]  LAST_COL = 8'(IMG_W - K);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [7:0]  w_row_nxt;
    logic [7:0]  w_col_nxt;
    logic [15:0] w_need;
    logic [15:0] w_base;
    logic        w_pix_ready;
    logic        w_cnt_clear;
    logic        w_cnt_keep;
    logic        w_win_valid;
    logic        w_done;
    logic        w_last;

    // Pixel count required before window (row,col) is fully buffered
    assign w_need = ({8'd0, r_row} + KM1) * W16 + {8'd0, r_col} + K16;
    assign w_base = {8'd0, r_row} * W16 + {8'd0, r_col};
    assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_pix_ready = 1'b0;
        w_cnt_clear = 1'b1;
        w_cnt_keep  = 1'b1;
        w_win_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_row_nxt = 8'd0;
                w_col_nxt = 8'd0;
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_clear = 1'b0;
                w_pix_ready = (i_pix_count < TOTAL);
                w_cnt_keep  = !(i_pix_valid && w_pix_ready);
                w_win_valid = (i_pix_count >= w_need);
                if (w_win_valid && i_win_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else if (r_col < LAST_COL) begin
                        w_col_nxt = r_col + 8'd1;
                    end else begin
                        w_col_nxt = 8'd0;
                        w_row_nxt = r_row + 8'd1;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_row_nxt   = 8'd0;
                w_col_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_row_nxt   = 8'd0;
                w_col_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_row   <= 8'd0;
            r_col   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    assign o_pix_ready = w_pix_ready;
    assign o_cnt_clear = w_cnt_clear;
    assign o_cnt_keep  = w_cnt_keep;
    assign o_win_valid = w_win_valid;
    assign o_win_row   = r_row;
    assign o_win_col   = r_col;
    assign o_win_base  = w_base;
    assign o_busy      = (r_state == S_RUN);
    assign o_done      = w_done;

endmodule
